// File: rtl/wf_pkg.sv
// Shared encodings for the multi-channel waveform player.
// Playback modes, FSM states and trigger polarity.
package wf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_TRG = 2'd1,
        ST_RUN      = 2'd2,
        ST_HOLD     = 2'd3
    } state_t;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_LOOP    = 2'b01;
    localparam logic [1:0] MODE_NREP    = 2'b10;

    localparam logic TRG_RISE = 1'b0;
    localparam logic TRG_FALL = 1'b1;

endpackage

// File: rtl/wf_dpram.sv
// Simple dual-port waveform table: one write port, one registered
// read port, read-first on address collision.
module wf_dpram #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 65000,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;

    assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_W);

    // Both updates are non-blocking, so a same-address read sees old data.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/wf_player_multi.sv
// Multi-channel waveform sequencer: plays the table to the set-point
// outputs, one point per step strobe, after an external trigger.
module wf_player_multi
    import wf_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int CH_NUM = 2,
    parameter int DEPTH  = 65000,
    parameter int AWIDTH = $clog2(DEPTH),
    parameter int REP_W  = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_en,
    input  logic [AWIDTH-1:0]        i_wr_addr,
    input  logic [DWIDTH*CH_NUM-1:0] i_wr_data,
    input  logic                     i_en,
    input  logic [1:0]               i_mode,
    input  logic [AWIDTH:0]          i_len,
    input  logic [REP_W-1:0]         i_rep_num,
    input  logic                     i_trg,
    input  logic                     i_trg_pol,
    input  logic                     i_step,
    output logic [DWIDTH*CH_NUM-1:0] o_sp,
    output logic                     o_sp_valid,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [AWIDTH-1:0]        o_idx,
    output logic [REP_W-1:0]         o_rep_cnt
);

    localparam int WW = DWIDTH * CH_NUM;
    localparam logic [AWIDTH:0]  DEPTH_L = (AWIDTH+1)'(DEPTH);
    localparam logic [REP_W-1:0] REP_MAX = {REP_W{1'b1}};

    state_t            state;
    state_t            state_nx;
    logic              trg_s1;
    logic              trg_s2;
    logic              trg_s3;
    logic              trg_evt;
    logic [1:0]        mode_q;
    logic [AWIDTH:0]   len_q;
    logic [AWIDTH:0]   len_eff;
    logic [REP_W-1:0]  rep_q;
    logic [REP_W-1:0]  rep_cnt;
    logic [REP_W-1:0]  rep_inc;
    logic [AWIDTH-1:0] idx;
    logic              last;
    logic              is_loop;
    logic              is_nrep;
    logic              step_run;
    logic              upd0;
    logic              upd1;
    logic              busy;
    logic              done_nx;
    logic [WW-1:0]     rd_data;

    // Two sync flops, one history flop, registered edge pulse.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            trg_s1  <= 1'b0;
            trg_s2  <= 1'b0;
            trg_s3  <= 1'b0;
            trg_evt <= 1'b0;
        end else begin
            trg_s1  <= i_trg;
            trg_s2  <= trg_s1;
            trg_s3  <= trg_s2;
            if (i_trg_pol == TRG_RISE) begin
                trg_evt <= trg_s2 & ~trg_s3;
            end else begin
                trg_evt <= trg_s3 & ~trg_s2;
            end
        end
    end

    always_comb begin
        if ((i_len == '0) || (i_len > DEPTH_L)) begin
            len_eff = DEPTH_L;
        end else begin
            len_eff = i_len;
        end
    end

    always_comb begin
        is_loop = 1'b0;
        is_nrep = 1'b0;
        case (mode_q)
            MODE_LOOP:    is_loop = 1'b1;
            MODE_NREP:    is_nrep = 1'b1;
            MODE_ONESHOT: ;
            default:      ;
        endcase
    end

    assign last     = ({1'b0, idx} == (len_q - 1'b1));
    assign rep_inc  = rep_cnt + 1'b1;
    assign step_run = (state == ST_RUN) && i_step;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state  <= ST_IDLE;
            o_done <= 1'b0;
        end else begin
            state  <= state_nx;
            o_done <= done_nx;
        end
    end

    // Priority: enable, then idle exit, then trigger, then step.
    always_comb begin
        state_nx = state;
        if (!i_en) begin
            state_nx = ST_IDLE;
        end else if (state == ST_IDLE) begin
            state_nx = ST_WAIT_TRG;
        end else if (trg_evt) begin
            state_nx = ST_RUN;
        end else if (step_run && last && !is_loop) begin
            if (!is_nrep || (rep_inc == rep_q)) begin
                state_nx = ST_HOLD;
            end
        end
    end

    always_comb begin
        busy    = (state == ST_RUN);
        done_nx = (state_nx == ST_HOLD) && (state != ST_HOLD);
    end

    assign o_busy = busy;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            idx     <= '0;
            rep_cnt <= '0;
            upd0    <= 1'b0;
            mode_q  <= MODE_ONESHOT;
            len_q   <= DEPTH_L;
            rep_q   <= REP_W'(1);
        end else begin
            upd0 <= 1'b0;
            if (!i_en) begin
                idx     <= '0;
                rep_cnt <= '0;
            end else if (state == ST_IDLE) begin
                idx     <= AWIDTH'(len_eff - 1'b1);
                rep_cnt <= '0;
                upd0    <= 1'b1;
            end else if (trg_evt) begin
                idx     <= '0;
                rep_cnt <= '0;
                upd0    <= 1'b1;
                mode_q  <= i_mode;
                len_q   <= len_eff;
                rep_q   <= (i_rep_num == '0) ? REP_W'(1) : i_rep_num;
            end else if (step_run) begin
                if (!last) begin
                    idx  <= idx + 1'b1;
                    upd0 <= 1'b1;
                end else if (is_loop) begin
                    idx  <= '0;
                    upd0 <= 1'b1;
                    if (rep_cnt != REP_MAX) begin
                        rep_cnt <= rep_inc;
                    end
                end else if (is_nrep) begin
                    rep_cnt <= rep_inc;
                    if (rep_inc != rep_q) begin
                        idx  <= '0;
                        upd0 <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_idx     = idx;
    assign o_rep_cnt = rep_cnt;

    wf_dpram #(
        .WIDTH (WW),
        .DEPTH (DEPTH),
        .AW    (AWIDTH)
    ) u_ram (
        .clk     (i_clk),
        .wr_en   (i_wr_en),
        .wr_addr (i_wr_addr),
        .wr_data (i_wr_data),
        .rd_addr (idx),
        .rd_data (rd_data)
    );

    // upd1 marks rd_data as belonging to a freshly issued index.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            upd1       <= 1'b0;
            o_sp       <= '0;
            o_sp_valid <= 1'b0;
        end else begin
            upd1       <= upd0;
            o_sp_valid <= upd1 && (state != ST_IDLE);
            if (upd1 && (state != ST_IDLE)) begin
                o_sp <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_wf_player_multi.sv
// Directed bench for wf_player_multi with a 16-entry table.
module tb_wf_player_multi;

    localparam int DW    = 32;
    localparam int CH    = 2;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int RW    = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW*CH-1:0]  wr_data;
    logic              en;
    logic [1:0]        mode;
    logic [AW:0]       len;
    logic [RW-1:0]     rep_num;
    logic              trg;
    logic              trg_pol;
    logic              step_in;
    logic [DW*CH-1:0]  sp;
    logic              sp_valid;
    logic              busy;
    logic              done;
    logic [AW-1:0]     idx;
    logic [RW-1:0]     rep_cnt;

    int errors    = 0;
    int checks    = 0;
    int done_cnt  = 0;
    int valid_cnt = 0;

    wf_player_multi #(
        .DWIDTH (DW),
        .CH_NUM (CH),
        .DEPTH  (DEPTH),
        .AWIDTH (AW),
        .REP_W  (RW)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .i_en       (en),
        .i_mode     (mode),
        .i_len      (len),
        .i_rep_num  (rep_num),
        .i_trg      (trg),
        .i_trg_pol  (trg_pol),
        .i_step     (step_in),
        .o_sp       (sp),
        .o_sp_valid (sp_valid),
        .o_busy     (busy),
        .o_done     (done),
        .o_idx      (idx),
        .o_rep_cnt  (rep_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (sp_valid) valid_cnt++;
    end

    function automatic logic [63:0] w(input int v);
        return {32'(v + 1000), 32'(v)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int a, input int v);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = w(v);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(busy), 64'd1);
    endtask

    task automatic trig_rise(input string tag, input logic [63:0] first);
        trg = 1'b1;
        wait_busy({tag, "_busy"});
        trg = 1'b0;
        valid_cnt = 0;
        chk({tag, "_idx"}, 64'(idx), 64'd0);
        tick(2);
        chk({tag, "_sp"}, sp, first);
    endtask

    task automatic step(input string tag, input logic [63:0] esp,
                        input logic edone, input logic ebusy);
        step_in = 1'b1;
        @(negedge clk);
        step_in = 1'b0;
        chk({tag, "_done"}, 64'(done), 64'(edone));
        chk({tag, "_busy"}, 64'(busy), 64'(ebusy));
        tick(2);
        chk({tag, "_sp"}, sp, esp);
    endtask

    task automatic restart();
        en = 1'b0;
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int os[5];
        int lp[7];
        os = '{20, 30, 40, 40, 40};
        lp = '{2, 3, 1, 2, 3, 1, 2};
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        en = 1'b0; mode = 2'b00; len = '0; rep_num = '0;
        trg = 1'b0; trg_pol = 1'b0; step_in = 1'b0;
        #1;
        chk("rst_sp", sp, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_idx", 64'(idx), 64'd0);
        tick(2);
        rst = 1'b1;
        tick(1);

        // one-shot, L=4
        for (int i = 0; i < 4; i++) wr(i, 10 * (i + 1));
        len = 5'd4; mode = 2'b00;
        en = 1'b1;
        tick(4);
        chk("wait_sp", sp, w(40));
        chk("wait_idx", 64'(idx), 64'd3);
        chk("wait_busy", 64'(busy), 64'd0);
        done_cnt = 0;
        trig_rise("os_trg", w(10));
        for (int k = 0; k < 5; k++)
            step($sformatf("os%0d", k), w(os[k]), k == 3, k < 3);
        chk("os_done_cnt", 64'(done_cnt), 64'd1);
        chk("os_valid_cnt", 64'(valid_cnt), 64'd4);
        chk("os_idx", 64'(idx), 64'd3);

        // disable clears counters, o_sp holds
        restart();
        chk("dis_idx", 64'(idx), 64'd0);
        chk("dis_sp", sp, w(40));

        // loop, L=3
        for (int i = 0; i < 3; i++) wr(i, i + 1);
        len = 5'd3; mode = 2'b01;
        en = 1'b1;
        tick(4);
        trig_rise("lp_trg", w(1));
        for (int k = 0; k < 7; k++)
            step($sformatf("lp%0d", k), w(lp[k]), 1'b0, 1'b1);
        chk("lp_rep", 64'(rep_cnt), 64'd2);

        // N-repeat, rep_num=2, L=2
        restart();
        wr(0, 5); wr(1, 6);
        len = 5'd2; mode = 2'b10; rep_num = 16'd2;
        en = 1'b1;
        tick(4);
        done_cnt = 0;
        trig_rise("nr_trg", w(5));
        step("nr0", w(6), 1'b0, 1'b1);
        step("nr1", w(5), 1'b0, 1'b1);
        chk("nr_rep1", 64'(rep_cnt), 64'd1);
        step("nr2", w(6), 1'b0, 1'b1);
        step("nr3", w(6), 1'b1, 1'b0);
        step("nr4", w(6), 1'b0, 1'b0);
        chk("nr_rep", 64'(rep_cnt), 64'd2);
        chk("nr_done_cnt", 64'(done_cnt), 64'd1);

        // retrigger at idx 2 with a colliding step
        restart();
        for (int i = 0; i < 4; i++) wr(i, 10 * (i + 1));
        len = 5'd4; mode = 2'b00;
        en = 1'b1;
        tick(4);
        trig_rise("rt_trg", w(10));
        step("rt0", w(20), 1'b0, 1'b1);
        step("rt1", w(30), 1'b0, 1'b1);
        chk("rt_idx2", 64'(idx), 64'd2);
        trg = 1'b1;
        tick(3);
        chk("rt_pre_idx", 64'(idx), 64'd2);
        step_in = 1'b1;
        tick(1);
        step_in = 1'b0;
        trg = 1'b0;
        chk("rt_idx0", 64'(idx), 64'd0);
        chk("rt_rep0", 64'(rep_cnt), 64'd0);
        chk("rt_busy", 64'(busy), 64'd1);
        tick(2);
        chk("rt_sp", sp, w(10));
        step("rt2", w(20), 1'b0, 1'b1);

        // falling polarity: rising ignored, short low pulse accepted
        restart();
        trg_pol = 1'b1;
        en = 1'b1;
        tick(4);
        trg = 1'b1;
        tick(8);
        chk("fp_rise_busy", 64'(busy), 64'd0);
        chk("fp_rise_idx", 64'(idx), 64'd3);
        #3 trg = 1'b0;
        #4 trg = 1'b1;
        wait_busy("fp_busy");
        chk("fp_idx", 64'(idx), 64'd0);
        tick(2);
        chk("fp_sp", sp, w(10));
        step("fp0", w(20), 1'b0, 1'b1);

        // async reset mid-run
        #2 rst = 1'b0;
        #1;
        chk("ar_sp", sp, 64'd0);
        chk("ar_valid", 64'(sp_valid), 64'd0);
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_done", 64'(done), 64'd0);
        chk("ar_idx", 64'(idx), 64'd0);
        chk("ar_rep", 64'(rep_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        tick(3);
        chk("ar_wait_sp", sp, w(40));
        chk("ar_wait_idx", 64'(idx), 64'd3);
        chk("ar_wait_busy", 64'(busy), 64'd0);

        // length boundaries map to DEPTH
        restart();
        len = 5'd0;
        en = 1'b1;
        tick(2);
        chk("len0_idx", 64'(idx), 64'd15);
        restart();
        len = 5'd20;
        en = 1'b1;
        tick(2);
        chk("len20_idx", 64'(idx), 64'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
